// File: rtl/clkdiv_pkg.sv
// Shared constants for the clock-divider slice: system clock rate and
// divisors that give common clk_out frequencies from basys_clk.
package clkdiv_pkg;

  localparam int unsigned CLK_HZ = 100_000_000;

  // Divisor D so that clk_out (period 2*(D+1) cycles) runs at f_hz.
  function automatic logic [31:0] div_for_hz(input int unsigned f_hz);
    return CLK_HZ / (2 * f_hz) - 1;
  endfunction

  localparam logic [31:0] DIV_1HZ     = div_for_hz(1);
  localparam logic [31:0] DIV_10HZ    = div_for_hz(10);
  localparam logic [31:0] DIV_1KHZ    = div_for_hz(1_000);
  localparam logic [31:0] DIV_6P25MHZ = div_for_hz(6_250_000);

endpackage

// File: rtl/clkdiv_channel.sv
// One divider channel: counts to a shadowed divisor, emits a tick strobe and
// toggles a 50%-duty square wave at every period boundary.
module clkdiv_channel
  import clkdiv_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             basys_clk,
  input  logic             reset,
  input  logic             en,
  input  logic             sync_clr,
  input  logic [CNT_W-1:0] div,
  output logic             clk_out,
  output logic             tick
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_active_div;
  logic             r_clk_out;
  logic             r_tick;
  logic             w_terminal;

  // Using >= keeps the all-ones divisor terminal, so r_cnt never wraps.
  assign w_terminal = (r_cnt >= r_active_div);

  always_ff @(posedge basys_clk or posedge reset) begin
    if (reset) begin
      r_cnt        <= '0;
      r_active_div <= '0;
      r_clk_out    <= 1'b0;
      r_tick       <= 1'b0;
    end else if (sync_clr || !en) begin
      r_cnt        <= '0;
      r_active_div <= div;
      r_clk_out    <= 1'b0;
      r_tick       <= 1'b0;
    end else if (w_terminal) begin
      // New divisor is only adopted here, which keeps every phase whole.
      r_cnt        <= '0;
      r_active_div <= div;
      r_clk_out    <= ~r_clk_out;
      r_tick       <= 1'b1;
    end else begin
      r_cnt        <= r_cnt + 1'b1;
      r_tick       <= 1'b0;
    end
  end

  assign clk_out = r_clk_out;
  assign tick    = r_tick;

endmodule

// File: rtl/multi_clock_divider.sv
// N independent runtime-programmable clock dividers sharing reset and a
// phase-align clear; feeds display, debounce and animation logic.
module multi_clock_divider
  import clkdiv_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32
) (
  input  logic                    basys_clk,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       en,
  input  logic                    sync_clr,
  input  logic [NUM_CH*CNT_W-1:0] count_in,
  output logic [NUM_CH-1:0]       clk_out,
  output logic [NUM_CH-1:0]       tick
);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    clkdiv_channel #(
      .CNT_W(CNT_W)
    ) u_ch (
      .basys_clk(basys_clk),
      .reset    (reset),
      .en       (en[g]),
      .sync_clr (sync_clr),
      .div      (count_in[g*CNT_W +: CNT_W]),
      .clk_out  (clk_out[g]),
      .tick     (tick[g])
    );
  end

endmodule

// File: tb/tb_multi_clock_divider.sv
// Bench for multi_clock_divider: cycle scoreboard plus directed edge checks.
module tb_multi_clock_divider;

  localparam int NCH = 4;
  localparam int CW  = 32;

  logic               basys_clk = 1'b0;
  logic               reset     = 1'b1;
  logic               sync_clr;
  logic [NCH-1:0]     en;
  logic [NCH*CW-1:0]  count_in;
  logic [NCH-1:0]     clk_out;
  logic [NCH-1:0]     tick;
  logic               en4;
  logic [3:0]         count4;
  logic               clk4;
  logic               tick4;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [31:0] cnt;
    logic [31:0] div;
    logic        ck;
    logic        tk;
  } ch_t;
  typedef logic [2*NCH+1:0] out_t;

  ch_t  m [NCH+1];
  out_t sb_q [$];

  multi_clock_divider #(.NUM_CH(NCH), .CNT_W(CW)) dut (
    .basys_clk(basys_clk), .reset(reset), .en(en), .sync_clr(sync_clr),
    .count_in(count_in), .clk_out(clk_out), .tick(tick)
  );

  multi_clock_divider #(.NUM_CH(1), .CNT_W(4)) dut4 (
    .basys_clk(basys_clk), .reset(reset), .en(en4), .sync_clr(sync_clr),
    .count_in(count4), .clk_out(clk4), .tick(tick4)
  );

  always #5 basys_clk = ~basys_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic ch_t nxt(input ch_t s, input logic e, input logic clr,
                              input logic [31:0] d);
    ch_t n;
    n = s;
    if (clr || !e) begin
      n.cnt = '0; n.div = d; n.ck = 1'b0; n.tk = 1'b0;
    end else if (s.cnt >= s.div) begin
      n.cnt = '0; n.div = d; n.ck = ~s.ck; n.tk = 1'b1;
    end else begin
      n.cnt = s.cnt + 32'd1; n.tk = 1'b0;
    end
    return n;
  endfunction

  function automatic logic [31:0] din(input int i);
    return (i == NCH) ? {28'd0, count4} : count_in[i*CW +: CW];
  endfunction

  function automatic logic ein(input int i);
    return (i == NCH) ? en4 : en[i];
  endfunction

  function automatic out_t exp_vec();
    out_t v;
    ch_t  n;
    v = '0;
    for (int i = 0; i <= NCH; i++) begin
      n = nxt(m[i], ein(i), sync_clr, din(i));
      if (i < NCH) begin
        v[NCH+2+i] = n.ck;
        v[2+i]     = n.tk;
      end else begin
        v[1] = n.ck;
        v[0] = n.tk;
      end
    end
    return v;
  endfunction

  // Reference model: expected outputs are queued at each edge.
  always @(posedge basys_clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i <= NCH; i++) m[i] <= '0;
    end else begin
      sb_q.push_back(exp_vec());
      for (int i = 0; i <= NCH; i++) m[i] <= nxt(m[i], ein(i), sync_clr, din(i));
    end
  end

  always begin
    @(posedge basys_clk);
    #1;
    if (sb_q.size() != 0)
      chk("sb", 32'({clk_out, tick, clk4, tick4}), 32'(sb_q.pop_front()));
  end

  task automatic step();
    @(posedge basys_clk);
    #1;
  endtask

  task automatic set_div(input int ch, input logic [31:0] d);
    count_in[ch*CW +: CW] = d;
  endtask

  initial begin
    int             prev_t;
    int             min_len;
    int             n4;
    int             p;
    logic           prev_clk;
    logic [NCH-1:0] et;
    logic [NCH-1:0] ec;
    int             dv [NCH];

    en = '0; sync_clr = 1'b0; count_in = '0; en4 = 1'b0; count4 = 4'd15;
    repeat (3) step();
    chk("rst_clk", 32'(clk_out), 32'd0);
    chk("rst_tick", 32'(tick), 32'd0);
    chk("rst_dut4", 32'({clk4, tick4}), 32'd0);

    // ch0 D=4 enabled straight out of reset: ticks on edges 1,6,11,16
    en = 4'b0001; set_div(0, 32'd4); en4 = 1'b1;
    reset = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      step();
      chk("t1_tick", 32'(tick[0]), 32'(k % 5 == 1));
      chk("t1_clk", 32'(clk_out[0]), 32'(((k - 1) / 5) % 2 == 0));
    end

    // divisor 4 -> 1 while cnt=2: old period ends at edge 21
    prev_t = 16; min_len = 1000; prev_clk = clk_out[0];
    for (int k = 17; k <= 30; k++) begin
      step();
      chk("t2_tick", 32'(tick[0]), 32'(k >= 21 && k % 2 == 1));
      if (clk_out[0] != prev_clk) begin
        if (k - prev_t < min_len) min_len = k - prev_t;
        prev_t = k;
        prev_clk = clk_out[0];
      end
      if (k == 18) set_div(0, 32'd1);
    end
    chk("t2_minphase", 32'(min_len), 32'd2);

    // D=0 on ch1
    en[1] = 1'b1; set_div(1, 32'd0);
    for (int k = 1; k <= 6; k++) begin
      step();
      chk("t3_tick", 32'(tick[1]), 32'd1);
      chk("t3_clk", 32'(clk_out[1]), 32'(k % 2));
    end

    // phase-align clear with D = 1,2,3,6
    dv = '{1, 2, 3, 6};
    for (int i = 1; i < NCH; i++) set_div(i, 32'(dv[i]));
    en = 4'b1111;
    repeat (5) step();
    sync_clr = 1'b1;
    step();
    chk("t4_clr_clk", 32'(clk_out), 32'd0);
    chk("t4_clr_tick", 32'(tick), 32'd0);
    sync_clr = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      step();
      for (int i = 0; i < NCH; i++) begin
        p = dv[i] + 1;
        et[i] = (k % p == 0);
        ec[i] = ((k / p) % 2 == 1);
      end
      chk("t4_tick", 32'(tick), 32'(et));
      chk("t4_clk", 32'(clk_out), 32'(ec));
    end

    // drop en[2] mid-period, then re-enable
    en[2] = 1'b0;
    step();
    chk("t5_en_clk", 32'(clk_out[2]), 32'd0);
    chk("t5_en_tick", 32'(tick[2]), 32'd0);
    en[2] = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      chk("t5_re_tick", 32'(tick[2]), 32'(k % 4 == 0));
      chk("t5_re_clk", 32'(clk_out[2]), 32'((k / 4) % 2 == 1));
    end

    // asynchronous reset between edges
    #2;
    reset = 1'b1;
    #1;
    chk("t5_async_out", 32'({clk_out, tick}), 32'd0);
    chk("t5_async_dut4", 32'({clk4, tick4}), 32'd0);
    step();
    chk("t5_hold_out", 32'({clk_out, tick}), 32'd0);
    reset = 1'b0;
    for (int j = 0; j <= 8; j++) begin
      step();
      for (int i = 0; i < NCH; i++) begin
        p = dv[i] + 1;
        et[i] = (j % p == 0);
        ec[i] = ((j / p) % 2 == 0);
      end
      chk("t5_rel_tick", 32'(tick), 32'(et));
      chk("t5_rel_clk", 32'(clk_out), 32'(ec));
    end

    // CNT_W=4, D=15: exactly one tick per 16 cycles
    en4 = 1'b0;
    step();
    en4 = 1'b1;
    n4 = 0;
    for (int k = 1; k <= 80; k++) begin
      step();
      if (tick4) n4++;
      chk("t6_tick", 32'(tick4), 32'(k % 16 == 0));
    end
    chk("t6_count", 32'(n4), 32'd5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
